fifo_ctrl: RTL and testbench

- Synchronous FIFO controller sitting directly upstream of the team's dual-port RAM (RAM_WIDTH x RAM_DEPTH); it owns that RAM's wr_enb/rd_enb/wr_addr/rd_addr/data_in pins and consumes its data_out.
- It turns a client-side push/pop interface into RAM accesses, keeps circular read/write pointers and an occupancy count, and reports full, empty, almost-full, almost-empty and sticky overflow/underflow errors.
- It is the building block for the PCIe lane/VC buffers.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_ptr.sv | 24 ++
 rtl/fifo_ctrl.sv | 116 +++++++++++
 tb/tb_fifo_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and types for the synchronous FIFO controller and its pointer registers.
package fifo_pkg;

  localparam int RAM_WIDTH_DEF = 10;
  localparam int RAM_DEPTH_DEF = 8;
  localparam int ADDR_SIZE_DEF = 3;
  localparam int PTR_W         = ADDR_SIZE_DEF + 1;
  localparam int AF_THRESH_DEF = 6;
  localparam int AE_THRESH_DEF = 2;

  // Encodes {push_ok, pop_ok} so the count update reads as an operation.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_ptr.sv
// Circular pointer register: increments on i_inc, MSB acts as the wrap bit.
module fifo_ptr #(
  parameter int PTR_W = fifo_pkg::PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [PTR_W-1:0] o_ptr
);

  logic [PTR_W-1:0] r_ptr;

  // NOTE: state uses <= so every flop samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + PTR_W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM with registered read data;
// owns the pointers, occupancy count, status flags and sticky error bits.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int RAM_WIDTH = RAM_WIDTH_DEF,
  parameter int RAM_DEPTH = RAM_DEPTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int AF_THRESH = AF_THRESH_DEF,
  parameter int AE_THRESH = AE_THRESH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [RAM_WIDTH-1:0] data_in,
  output logic [RAM_WIDTH-1:0] data_out,
  output logic                 data_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow_err,
  output logic                 underflow_err,
  output logic                 mem_wr_enb,
  output logic                 mem_rd_enb,
  output logic [ADDR_SIZE-1:0] mem_wr_addr,
  output logic [ADDR_SIZE-1:0] mem_rd_addr,
  output logic [RAM_WIDTH-1:0] mem_data_in,
  input  logic [RAM_WIDTH-1:0] mem_data_out
);

  localparam int CNT_W = ADDR_SIZE + 1;

  logic [CNT_W-1:0] w_wr_ptr;
  logic [CNT_W-1:0] w_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_data_valid;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  fifo_op_e         w_op;

  // Flags come from the count register only, so a full FIFO rejects a push even when a pop lands with it.
  assign w_full    = (r_count == CNT_W'(RAM_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push_ok = push & ~w_full;
  assign w_pop_ok  = pop & ~w_empty;
  assign w_op      = fifo_op_e'({w_push_ok, w_pop_ok});

  fifo_ptr #(.PTR_W(CNT_W)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_push_ok),
    .o_ptr (w_wr_ptr)
  );

  fifo_ptr #(.PTR_W(CNT_W)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_pop_ok),
    .o_ptr (w_rd_ptr)
  );

  always_comb begin
    // NOTE: default first, so every path assigns w_count_nxt and no latch is inferred.
    w_count_nxt = r_count;
    unique case (w_op)
      OP_PUSH: w_count_nxt = r_count + CNT_W'(1);
      OP_POP:  w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count      <= '0;
      r_data_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_count      <= w_count_nxt;
      r_data_valid <= w_pop_ok;
      r_overflow   <= r_overflow | (push & ~w_push_ok);
      r_underflow  <= r_underflow | (pop & ~w_pop_ok);
    end
  end

  // The wrap bits make the pointer difference equal the occupancy, including when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (r_count == CNT_W'(w_wr_ptr - w_rd_ptr));
    end
  end

  assign mem_wr_enb    = w_push_ok & rst;
  assign mem_rd_enb    = w_pop_ok & rst;
  assign mem_wr_addr   = w_wr_ptr[ADDR_SIZE-1:0];
  assign mem_rd_addr   = w_rd_ptr[ADDR_SIZE-1:0];
  assign mem_data_in   = data_in;
  assign data_out      = mem_data_out;
  assign data_valid    = r_data_valid;
  assign full          = w_full;
  assign empty         = w_empty;
  assign almost_full   = (r_count >= CNT_W'(AF_THRESH));
  assign almost_empty  = (r_count <= CNT_W'(AE_THRESH));
  assign count         = r_count;
  assign overflow_err  = r_overflow;
  assign underflow_err = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: a RAM model, a queue-based reference model,
// a vector table, directed corner sequences and randomized traffic.
module tb_fifo_ctrl;

  localparam int W  = 10;
  localparam int D  = 8;
  localparam int A  = 3;
  localparam int AF = 6;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         push;
  logic         pop;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [A:0]   count;
  logic         overflow_err;
  logic         underflow_err;
  logic         mem_wr_enb;
  logic         mem_rd_enb;
  logic [A-1:0] mem_wr_addr;
  logic [A-1:0] mem_rd_addr;
  logic [W-1:0] mem_data_in;
  logic [W-1:0] mem_data_out;

  always #5 clk = ~clk;

  fifo_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .push          (push),
    .pop           (pop),
    .data_in       (data_in),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .count         (count),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err),
    .mem_wr_enb    (mem_wr_enb),
    .mem_rd_enb    (mem_rd_enb),
    .mem_wr_addr   (mem_wr_addr),
    .mem_rd_addr   (mem_rd_addr),
    .mem_data_in   (mem_data_in),
    .mem_data_out  (mem_data_out)
  );

  // Dual-port RAM with a registered read port.
  logic [W-1:0] ram [D];
  always @(posedge clk) begin
    if (mem_wr_enb) ram[mem_wr_addr] <= mem_data_in;
    if (mem_rd_enb) mem_data_out <= ram[mem_rd_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a queue of stored words plus push/pop totals for addresses.
  int model_q[$];
  int m_wr  = 0;
  int m_rd  = 0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;
  bit m_dv  = 1'b0;
  int m_dout = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit p, input bit q, input int d);
    bit exp_push_ok;
    bit exp_pop_ok;
    int sz;
    @(negedge clk);
    rst = r; push = p; pop = q; data_in = W'(d);
    #1;
    sz = model_q.size();
    exp_push_ok = r && p && (sz < D);
    exp_pop_ok  = r && q && (sz > 0);
    check("mem_wr_enb", int'(mem_wr_enb), int'(exp_push_ok));
    check("mem_rd_enb", int'(mem_rd_enb), int'(exp_pop_ok));
    if (r) begin
      check("mem_wr_addr", int'(mem_wr_addr), m_wr % D);
      check("mem_rd_addr", int'(mem_rd_addr), m_rd % D);
    end
    if (exp_push_ok) check("mem_data_in", int'(mem_data_in), d);
    @(posedge clk);
    if (!r) begin
      model_q.delete();
      m_wr = 0; m_rd = 0; m_ovf = 0; m_unf = 0; m_dv = 0;
    end else begin
      m_ovf = m_ovf | (p && !exp_push_ok);
      m_unf = m_unf | (q && !exp_pop_ok);
      m_dv  = exp_pop_ok;
      if (exp_pop_ok) begin
        m_dout = model_q.pop_front();
        m_rd++;
      end
      if (exp_push_ok) begin
        model_q.push_back(d);
        m_wr++;
      end
    end
    #1;
    sz = model_q.size();
    check("count", int'(count), sz);
    check("full", int'(full), int'(sz == D));
    check("empty", int'(empty), int'(sz == 0));
    check("almost_full", int'(almost_full), int'(sz >= AF));
    check("almost_empty", int'(almost_empty), int'(sz <= AE));
    check("data_valid", int'(data_valid), int'(m_dv));
    check("overflow_err", int'(overflow_err), int'(m_ovf));
    check("underflow_err", int'(underflow_err), int'(m_unf));
    if (m_dv) check("data_out", int'(data_out), m_dout);
    check("ptr_invariant", int'(count) % D, (int'(mem_wr_addr) - int'(mem_rd_addr)) & (D - 1));
  endtask

  typedef struct {
    bit push;
    bit pop;
    int data;
    int exp_count;
    bit exp_empty;
    bit exp_dv;
    int exp_dout;
    bit exp_unf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int pp;
    int qp;
    rst = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;

    vecs[0] = '{1'b1, 1'b0, 'hFF,  1, 1'b0, 1'b0, 0,     1'b0};
    vecs[1] = '{1'b1, 1'b0, 'hCC,  2, 1'b0, 1'b0, 0,     1'b0};
    vecs[2] = '{1'b0, 1'b1, 0,     1, 1'b0, 1'b1, 'hFF,  1'b0};
    vecs[3] = '{1'b0, 1'b1, 0,     0, 1'b1, 1'b1, 'hCC,  1'b0};
    vecs[4] = '{1'b0, 1'b0, 0,     0, 1'b1, 1'b0, 0,     1'b0};
    vecs[5] = '{1'b0, 1'b1, 0,     0, 1'b1, 1'b0, 0,     1'b1};
    vecs[6] = '{1'b1, 1'b1, 'h155, 1, 1'b0, 1'b0, 0,     1'b1};

    // Reset and idle.
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Table: basic push/pop, latency, underflow and push+pop on empty.
    for (int i = 0; i < 7; i++) begin
      step(1, vecs[i].push, vecs[i].pop, vecs[i].data);
      check($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
      check($sformatf("vec%0d_empty", i), int'(empty), int'(vecs[i].exp_empty));
      check($sformatf("vec%0d_dv", i), int'(data_valid), int'(vecs[i].exp_dv));
      check($sformatf("vec%0d_unf", i), int'(underflow_err), int'(vecs[i].exp_unf));
      if (vecs[i].exp_dv) check($sformatf("vec%0d_dout", i), int'(data_out), vecs[i].exp_dout);
    end

    // Fill to full, overflow, push+pop at full and mid-level.
    step(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, i);
      check($sformatf("fill%0d_af", i), int'(almost_full), int'(i >= 5));
    end
    check("fill_full", int'(full), 1);
    step(1, 1, 0, 8);
    check("ovf_set", int'(overflow_err), 1);
    check("ovf_count", int'(count), 8);
    step(1, 1, 1, 9);
    check("full_pp_count", int'(count), 7);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 1, 1, 'h3A);
    check("mid_pp_count", int'(count), 4);
    check("ovf_sticky", int'(overflow_err), 1);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0);

    // Wrap-around with simultaneous push/pop, then drain.
    step(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, i > 0, 'h100 + i);
    step(1, 0, 1, 0);
    check("wrap_empty", int'(empty), 1);

    // Reset with count=5 and errors set; reset overrides push/pop.
    step(1, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 'h200 + i);
    check("pre_rst_count", int'(count), 5);
    step(0, 1, 1, 'h3FF);
    check("rst_count", int'(count), 0);
    check("rst_unf", int'(underflow_err), 0);

    // Randomized traffic with alternating fill/drain bias and rare resets.
    step(1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      pp = ((i / 50) % 2 == 0) ? 70 : 30;
      qp = 100 - pp;
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 99) < pp,
           $urandom_range(0, 99) < qp,
           int'($urandom_range(0, 1023)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
